// File: rtl/snoop_responder.sv
// Snoop responder: models a peer cache on the shared bus. Looks up bus
// operations in a small fully-associative MESI directory, returns the snoop
// result, applies the MESI transition and drives modified-line writebacks.
module snoop_responder #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned WB_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_addr,
  output logic              result_valid,
  output logic [1:0]        snoop_result,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              install_valid,
  output logic              install_ready,
  input  logic [ADDR_W-1:0] install_addr,
  input  logic [1:0]        install_state,
  output logic              protocol_err
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int unsigned TAG_W       = ADDR_W - OFFSET_BITS;
  localparam int unsigned IDX_W       = $clog2(ENTRIES);
  localparam int unsigned CNT_W       = $clog2(WB_CYCLES + 1);

  localparam logic [2:0] OP_READ       = 3'd1;
  localparam logic [2:0] OP_WRITE      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_RWIM       = 3'd4;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_E = 2'b10;
  localparam logic [1:0] ST_M = 2'b11;

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b10;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, WB} fsmStateT;

  fsmStateT           fsmState;
  logic [2:0]         opCode;
  logic [TAG_W-1:0]   opTag;
  logic               hitReg;
  logic [IDX_W-1:0]   hitIdx;
  logic [CNT_W-1:0]   wbCnt;
  logic [IDX_W-1:0]   victimPtr;
  logic [TAG_W-1:0]   entTag   [ENTRIES];
  logic [1:0]         entState [ENTRIES];

  logic               lkHit;
  logic [IDX_W-1:0]   lkIdx;
  logic [1:0]         lkState;
  logic               inHit;
  logic [IDX_W-1:0]   inIdx;
  logic               freeFound;
  logic [IDX_W-1:0]   freeIdx;
  logic [1:0]         respCode;
  logic               respErr;
  logic [TAG_W-1:0]   installTag;
  logic               unusedOffsetBits;

  assign installTag       = install_addr[ADDR_W-1:OFFSET_BITS];
  assign unusedOffsetBits = ^{op_addr[OFFSET_BITS-1:0], install_addr[OFFSET_BITS-1:0]};

  // An operation always wins over a simultaneous install request
  assign install_ready = (fsmState == IDLE) && !op_valid;

  // Directory search: operation tag match, install tag match, lowest free slot
  always_comb begin
    lkHit     = 1'b0;
    lkIdx     = '0;
    lkState   = ST_I;
    inHit     = 1'b0;
    inIdx     = '0;
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if ((entState[i] != ST_I) && (entTag[i] == opTag)) begin
        lkHit   = 1'b1;
        lkIdx   = IDX_W'(i);
        lkState = entState[i];
      end
      if ((entState[i] != ST_I) && (entTag[i] == installTag)) begin
        inHit = 1'b1;
        inIdx = IDX_W'(i);
      end
      if ((entState[i] == ST_I) && !freeFound) begin
        freeFound = 1'b1;
        freeIdx   = IDX_W'(i);
      end
    end
  end

  // Snoop result and protocol check for the captured operation
  always_comb begin
    respCode = RES_NOHIT;
    respErr  = 1'b0;
    case (opCode)
      OP_READ, OP_RWIM: begin
        if (lkHit) respCode = (lkState == ST_M) ? RES_HITM : RES_HIT;
      end
      OP_INVALIDATE: begin
        if (lkHit) begin
          respCode = RES_HIT;
          respErr  = (lkState == ST_E) || (lkState == ST_M);
        end
      end
      OP_WRITE: begin
        respErr = lkHit && ((lkState == ST_E) || (lkState == ST_M));
      end
      default: respErr = 1'b1;
    endcase
  end

  // Control FSM, registered outputs and directory updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsmState     <= IDLE;
      op_ready     <= 1'b1;
      result_valid <= 1'b0;
      snoop_result <= RES_NOHIT;
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      protocol_err <= 1'b0;
      opCode       <= '0;
      opTag        <= '0;
      hitReg       <= 1'b0;
      hitIdx       <= '0;
      wbCnt        <= '0;
      victimPtr    <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entTag[i]   <= '0;
        entState[i] <= ST_I;
      end
    end else begin
      result_valid <= 1'b0;
      protocol_err <= 1'b0;
      case (fsmState)
        IDLE: begin
          if (op_valid) begin
            opCode   <= op_code;
            opTag    <= op_addr[ADDR_W-1:OFFSET_BITS];
            op_ready <= 1'b0;
            fsmState <= LOOKUP;
          end else if (install_valid) begin
            if (inHit) begin
              entState[inIdx] <= install_state;
            end else if (install_state != ST_I) begin
              if (freeFound) begin
                entTag[freeIdx]   <= installTag;
                entState[freeIdx] <= install_state;
              end else begin
                entTag[victimPtr]   <= installTag;
                entState[victimPtr] <= install_state;
                victimPtr           <= victimPtr + IDX_W'(1);
              end
            end
          end
        end
        LOOKUP: begin
          hitReg       <= lkHit;
          hitIdx       <= lkIdx;
          result_valid <= 1'b1;
          snoop_result <= respCode;
          protocol_err <= respErr;
          fsmState     <= RESPOND;
        end
        RESPOND: begin
          if (hitReg) begin
            case (opCode)
              OP_READ:                 entState[hitIdx] <= ST_S;
              OP_RWIM, OP_INVALIDATE:  entState[hitIdx] <= ST_I;
              default: ;
            endcase
          end
          if (snoop_result == RES_HITM) begin
            wb_valid <= 1'b1;
            wb_addr  <= {opTag, {OFFSET_BITS{1'b0}}};
            wbCnt    <= CNT_W'(WB_CYCLES - 1);
            fsmState <= WB;
          end else begin
            op_ready <= 1'b1;
            fsmState <= IDLE;
          end
        end
        WB: begin
          if (wbCnt == '0) begin
            wb_valid <= 1'b0;
            op_ready <= 1'b1;
            fsmState <= IDLE;
          end else begin
            wbCnt <= wbCnt - CNT_W'(1);
          end
        end
        default: fsmState <= IDLE;
      endcase
    end
  end

endmodule
